rename_map: RTL and testbench



---
 rtl/rename_map.sv | 180 ++++++++++++++++++
 tb/tb_rename_map.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map.sv
// rtl/rename_map.sv - 4-wide register rename: SRAT/CRAT maps, one rename stage, 2-entry output FIFO
module rename_map #(
  parameter int ARCH  = 32,
  parameter int PHYS  = 48,
  parameter int ABITS = $clog2(ARCH),
  parameter int PBITS = $clog2(PHYS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_dec_valid,
  output logic               o_dec_ready,
  input  logic [2:0]         i_dec_count,
  input  logic [4*ABITS-1:0] i_dec_rs1,
  input  logic [4*ABITS-1:0] i_dec_rs2,
  input  logic [4*ABITS-1:0] i_dec_rd,
  input  logic [3:0]         i_dec_rd_we,
  output logic [2:0]         o_fl_req_count,
  input  logic [4*PBITS-1:0] i_fl_req,
  input  logic [PBITS-1:0]   i_fl_avail,
  output logic               o_ren_valid,
  input  logic               i_ren_ready,
  output logic [2:0]         o_ren_count,
  output logic [4*PBITS-1:0] o_ren_prs1,
  output logic [4*PBITS-1:0] o_ren_prs2,
  output logic [4*PBITS-1:0] o_ren_prd,
  output logic [4*PBITS-1:0] o_ren_prd_old,
  output logic [3:0]         o_ren_rd_we,
  input  logic [2:0]         i_cmt_count,
  input  logic [4*ABITS-1:0] i_cmt_rd,
  input  logic [4*PBITS-1:0] i_cmt_prd,
  input  logic [4*PBITS-1:0] i_cmt_prd_old,
  output logic [4*PBITS-1:0] o_fl_ret_p,
  output logic [2:0]         o_fl_ret_count,
  input  logic               i_flush
);
  typedef struct packed {
    logic [2:0]         count;
    logic [3:0]         we;
    logic [4*PBITS-1:0] prs1;
    logic [4*PBITS-1:0] prs2;
    logic [4*PBITS-1:0] prd;
    logic [4*PBITS-1:0] old;
  } grp_t;

  logic [PBITS-1:0]   srat     [ARCH];
  logic [PBITS-1:0]   crat     [ARCH];
  logic [PBITS-1:0]   crat_nxt [ARCH];

  logic               s1_valid;
  logic [2:0]         s1_count;
  logic [4*ABITS-1:0] s1_rs1, s1_rs2, s1_rd;
  logic [3:0]         s1_we;

  grp_t               fifo [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         fifo_count;

  grp_t               ren;
  logic [1:0]         tidx;
  logic [3:0]         dec_we;
  logic [2:0]         need;
  logic [2:0]         occ;
  logic               pop, accept;

  always_comb begin
    need   = '0;
    dec_we = '0;
    for (int k = 0; k < 4; k++) begin
      dec_we[k] = (3'(k) < i_dec_count) && i_dec_rd_we[k] && (i_dec_rd[k*ABITS +: ABITS] != '0);
      need      = need + {2'b0, dec_we[k]};
    end
  end

  assign pop            = o_ren_valid && i_ren_ready;
  assign occ            = {1'b0, fifo_count} + {2'b0, s1_valid} - {2'b0, pop};
  assign o_dec_ready    = i_rst_n && !i_flush && (occ <= 3'd1) && (PBITS'(need) <= i_fl_avail);
  assign accept         = i_dec_valid && o_dec_ready;
  assign o_fl_req_count = accept ? need : 3'd0;

  assign o_fl_ret_p     = i_cmt_prd_old;
  assign o_fl_ret_count = i_rst_n ? i_cmt_count : 3'd0;

  // Younger writers in the group override the SRAT lookup; later j in the loop wins.
  always_comb begin
    ren       = '0;
    ren.count = s1_count;
    ren.we    = s1_we;
    tidx      = '0;
    for (int i = 0; i < 4; i++) begin
      if (s1_we[i]) begin
        ren.prd[i*PBITS +: PBITS] = i_fl_req[tidx*PBITS +: PBITS];
        tidx = tidx + 2'd1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < s1_count) begin
        ren.prs1[i*PBITS +: PBITS] = srat[s1_rs1[i*ABITS +: ABITS]];
        ren.prs2[i*PBITS +: PBITS] = srat[s1_rs2[i*ABITS +: ABITS]];
        if (s1_we[i])
          ren.old[i*PBITS +: PBITS] = srat[s1_rd[i*ABITS +: ABITS]];
        for (int j = 0; j < i; j++) begin
          if (s1_we[j] && s1_rd[j*ABITS +: ABITS] == s1_rs1[i*ABITS +: ABITS])
            ren.prs1[i*PBITS +: PBITS] = ren.prd[j*PBITS +: PBITS];
          if (s1_we[j] && s1_rd[j*ABITS +: ABITS] == s1_rs2[i*ABITS +: ABITS])
            ren.prs2[i*PBITS +: PBITS] = ren.prd[j*PBITS +: PBITS];
          if (s1_we[i] && s1_we[j] && s1_rd[j*ABITS +: ABITS] == s1_rd[i*ABITS +: ABITS])
            ren.old[i*PBITS +: PBITS] = ren.prd[j*PBITS +: PBITS];
        end
        if (s1_rs1[i*ABITS +: ABITS] == '0) ren.prs1[i*PBITS +: PBITS] = '0;
        if (s1_rs2[i*ABITS +: ABITS] == '0) ren.prs2[i*PBITS +: PBITS] = '0;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ARCH; r++) crat_nxt[r] = crat[r];
    for (int k = 0; k < 4; k++)
      if ((3'(k) < i_cmt_count) && (i_cmt_rd[k*ABITS +: ABITS] != '0))
        crat_nxt[i_cmt_rd[k*ABITS +: ABITS]] = i_cmt_prd[k*PBITS +: PBITS];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < ARCH; r++) begin
        srat[r] <= PBITS'(r);
        crat[r] <= PBITS'(r);
      end
      s1_valid   <= 1'b0;
      s1_count   <= '0;
      s1_rs1     <= '0;
      s1_rs2     <= '0;
      s1_rd      <= '0;
      s1_we      <= '0;
      fifo[0]    <= '0;
      fifo[1]    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      for (int r = 0; r < ARCH; r++) crat[r] <= crat_nxt[r];
      if (i_flush) begin
        for (int r = 0; r < ARCH; r++) srat[r] <= crat_nxt[r];
        s1_valid   <= 1'b0;
        wr_ptr     <= 1'b0;
        rd_ptr     <= 1'b0;
        fifo_count <= '0;
      end else begin
        if (s1_valid)
          for (int i = 0; i < 4; i++)
            if (s1_we[i]) srat[s1_rd[i*ABITS +: ABITS]] <= ren.prd[i*PBITS +: PBITS];
        s1_valid <= accept;
        if (accept) begin
          s1_count <= i_dec_count;
          s1_rs1   <= i_dec_rs1;
          s1_rs2   <= i_dec_rs2;
          s1_rd    <= i_dec_rd;
          s1_we    <= dec_we;
        end
        // Ready rule reserves a slot, so S1 always drains without a full check.
        if (s1_valid) begin
          fifo[wr_ptr] <= ren;
          wr_ptr       <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        fifo_count <= fifo_count + {1'b0, s1_valid} - {1'b0, pop};
      end
    end
  end

  assign o_ren_valid   = (fifo_count != 2'd0);
  assign o_ren_count   = fifo[rd_ptr].count;
  assign o_ren_rd_we   = fifo[rd_ptr].we;
  assign o_ren_prs1    = fifo[rd_ptr].prs1;
  assign o_ren_prs2    = fifo[rd_ptr].prs2;
  assign o_ren_prd     = fifo[rd_ptr].prd;
  assign o_ren_prd_old = fifo[rd_ptr].old;

  always_ff @(posedge i_clk)
    if (i_rst_n && i_dec_valid) assert (i_dec_count >= 3'd1 && i_dec_count <= 3'd4);
endmodule

// File: tb/tb_rename_map.sv
// tb/tb_rename_map.sv - randomized bench for rename_map against a sequential map model
module tb_rename_map;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_ready;
  logic [2:0]  dec_count;
  logic [19:0] dec_rs1, dec_rs2, dec_rd;
  logic [3:0]  dec_rd_we;
  logic [2:0]  fl_req_count;
  logic [23:0] fl_req;
  logic [5:0]  fl_avail;
  logic        ren_valid, ren_ready;
  logic [2:0]  ren_count;
  logic [23:0] ren_prs1, ren_prs2, ren_prd, ren_prd_old;
  logic [3:0]  ren_rd_we;
  logic [2:0]  cmt_count;
  logic [19:0] cmt_rd;
  logic [23:0] cmt_prd, cmt_prd_old;
  logic [23:0] fl_ret_p;
  logic [2:0]  fl_ret_count;
  logic        flush;

  always #5 clk = ~clk;

  rename_map dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dec_valid(dec_valid), .o_dec_ready(dec_ready), .i_dec_count(dec_count),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2), .i_dec_rd(dec_rd), .i_dec_rd_we(dec_rd_we),
    .o_fl_req_count(fl_req_count), .i_fl_req(fl_req), .i_fl_avail(fl_avail),
    .o_ren_valid(ren_valid), .i_ren_ready(ren_ready), .o_ren_count(ren_count),
    .o_ren_prs1(ren_prs1), .o_ren_prs2(ren_prs2), .o_ren_prd(ren_prd),
    .o_ren_prd_old(ren_prd_old), .o_ren_rd_we(ren_rd_we),
    .i_cmt_count(cmt_count), .i_cmt_rd(cmt_rd), .i_cmt_prd(cmt_prd),
    .i_cmt_prd_old(cmt_prd_old), .o_fl_ret_p(fl_ret_p), .o_fl_ret_count(fl_ret_count),
    .i_flush(flush)
  );

  typedef struct {
    logic [102:0] bits;
    int           vis;
  } exp_t;

  int          n_cmp = 0, n_fail = 0, cyc = 0;
  logic [5:0]  m_srat [32];
  logic [5:0]  m_crat [32];
  exp_t        expq[$];
  logic [23:0] pend_tags;
  bit          use_ovr;
  logic [23:0] ovr_tags;
  bit          last_ready, last_valid;
  logic [2:0]  last_req, last_ret_count;
  logic [23:0] last_ret_p;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_srat[i] = 6'(i);
      m_crat[i] = 6'(i);
    end
    expq.delete();
    pend_tags = '0;
  endtask

  task automatic set_idle();
    dec_valid = 0; dec_count = 3'd1; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_rd_we = '0;
    fl_avail = 6'd16; ren_ready = 1; cmt_count = '0; cmt_rd = '0; cmt_prd = '0;
    cmt_prd_old = '0; flush = 0; use_ovr = 0;
  endtask

  task automatic set_slot(input int k, input int rs1, input int rs2, input int rd, input bit we);
    dec_rs1[k*5 +: 5] = 5'(rs1);
    dec_rs2[k*5 +: 5] = 5'(rs2);
    dec_rd[k*5 +: 5]  = 5'(rd);
    dec_rd_we[k]      = we;
  endtask

  task automatic rand_group();
    dec_valid = 1;
    dec_count = 3'($urandom_range(1, 4));
    for (int k = 0; k < 4; k++)
      set_slot(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom));
  endtask

  // One clock: compare every observable against the model, then advance the model.
  task automatic run_cycle();
    int          need, qs, t, a;
    bit          exp_valid, pop, exp_ready, acc;
    logic [102:0] got;
    logic [23:0] p1, p2, pd, po, tags;
    logic [3:0]  we;
    logic [5:0]  tag;
    fl_req = pend_tags;
    @(negedge clk);
    exp_valid = (expq.size() > 0) && (expq[0].vis <= cyc);
    n_cmp++;
    if (ren_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL ren_valid cyc=%0d got=%b exp=%b", cyc, ren_valid, exp_valid);
    end
    if (exp_valid) begin
      got = {ren_count, ren_rd_we, ren_prs1, ren_prs2, ren_prd, ren_prd_old};
      n_cmp++;
      if (got !== expq[0].bits) begin
        n_fail++;
        $display("FAIL ren_group cyc=%0d got=%h exp=%h", cyc, got, expq[0].bits);
      end
    end
    pop  = exp_valid && ren_ready;
    need = 0;
    for (int k = 0; k < int'(dec_count); k++)
      if (dec_rd_we[k] && dec_rd[k*5 +: 5] != 5'd0) need++;
    qs        = expq.size() - (pop ? 1 : 0);
    exp_ready = !flush && (qs <= 1) && (need <= int'(fl_avail));
    n_cmp++;
    if (dec_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL dec_ready cyc=%0d got=%b exp=%b", cyc, dec_ready, exp_ready);
    end
    n_cmp++;
    if (fl_req_count !== ((dec_valid && exp_ready) ? 3'(need) : 3'd0)) begin
      n_fail++;
      $display("FAIL fl_req_count cyc=%0d got=%0d need=%0d", cyc, fl_req_count, need);
    end
    n_cmp++;
    if (fl_ret_count !== cmt_count || fl_ret_p !== cmt_prd_old) begin
      n_fail++;
      $display("FAIL fl_ret cyc=%0d got=%0d/%h exp=%0d/%h", cyc, fl_ret_count, fl_ret_p, cmt_count, cmt_prd_old);
    end
    last_ready = dec_ready; last_req = fl_req_count; last_valid = ren_valid;
    last_ret_count = fl_ret_count; last_ret_p = fl_ret_p;
    acc = dec_valid && dec_ready;

    if (pop) void'(expq.pop_front());
    for (int k = 0; k < int'(cmt_count); k++)
      if (cmt_rd[k*5 +: 5] != 5'd0) m_crat[cmt_rd[k*5 +: 5]] = cmt_prd[k*6 +: 6];
    if (flush) begin
      m_srat = m_crat;
      expq.delete();
      pend_tags = 24'($urandom);
    end else if (acc) begin
      p1 = '0; p2 = '0; pd = '0; po = '0; we = '0; tags = '0; t = 0;
      for (int k = 0; k < int'(dec_count); k++) begin
        a = int'(dec_rs1[k*5 +: 5]);
        p1[k*6 +: 6] = (a == 0) ? 6'd0 : m_srat[a];
        a = int'(dec_rs2[k*5 +: 5]);
        p2[k*6 +: 6] = (a == 0) ? 6'd0 : m_srat[a];
        a = int'(dec_rd[k*5 +: 5]);
        if (dec_rd_we[k] && a != 0) begin
          tag = use_ovr ? ovr_tags[t*6 +: 6] : 6'($urandom_range(32, 47));
          tags[t*6 +: 6] = tag;
          po[k*6 +: 6]   = m_srat[a];
          pd[k*6 +: 6]   = tag;
          m_srat[a]      = tag;
          we[k]          = 1'b1;
          t++;
        end
      end
      expq.push_back('{bits: {dec_count, we, p1, p2, pd, po}, vis: cyc + 2});
      pend_tags = tags;
    end else begin
      pend_tags = 24'($urandom);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_idle();
    dec_valid = 1; set_slot(0, 1, 2, 3, 1); cmt_count = 3'd2;
    fl_req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ren_valid !== 1'b0 || dec_ready !== 1'b0 || fl_req_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got valid=%b ready=%b req=%0d exp 0/0/0", ren_valid, dec_ready, fl_req_count);
    end
    n_cmp++;
    if ({ren_count, ren_rd_we, ren_prs1, ren_prs2, ren_prd, ren_prd_old} !== 103'd0) begin
      n_fail++;
      $display("FAIL reset_data got nonzero ren data exp 0");
    end
    n_cmp++;
    if (fl_ret_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ret_count got=%0d exp=0", fl_ret_count);
    end
    set_idle();
    rst_n = 1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_basic();
    set_idle();
    dec_valid = 1; dec_count = 3'd2;
    set_slot(0, 2, 3, 1, 1);
    set_slot(1, 1, 1, 4, 1);
    use_ovr = 1; ovr_tags = {12'd0, 6'd33, 6'd32};
    run_cycle();
    n_cmp++;
    if (last_req !== 3'd2) begin
      n_fail++;
      $display("FAIL basic_req got=%0d exp=2", last_req);
    end
    set_idle();
    run_cycle();
    n_cmp++;
    if (ren_valid !== 1'b1 || ren_count !== 3'd2 || ren_rd_we !== 4'b0011 ||
        ren_prs1 !== {12'd0, 6'd32, 6'd2} || ren_prs2 !== {12'd0, 6'd32, 6'd3} ||
        ren_prd !== {12'd0, 6'd33, 6'd32} || ren_prd_old !== {12'd0, 6'd4, 6'd1}) begin
      n_fail++;
      $display("FAIL basic_group got v=%b c=%0d we=%b prs1=%h prs2=%h prd=%h old=%h exp 1/2/0011/000802/000803/000860/000101",
               ren_valid, ren_count, ren_rd_we, ren_prs1, ren_prs2, ren_prd, ren_prd_old);
    end
    run_cycle();
  endtask

  task automatic test_same_rd();
    set_idle();
    dec_valid = 1; dec_count = 3'd2;
    set_slot(0, 0, 0, 5, 1);
    set_slot(1, 5, 0, 5, 1);
    use_ovr = 1; ovr_tags = {12'd0, 6'd41, 6'd40};
    run_cycle();
    set_idle();
    run_cycle();
    n_cmp++;
    if (ren_prd_old[11:6] !== 6'd40 || ren_prs1[11:6] !== 6'd40 || ren_prd[11:6] !== 6'd41) begin
      n_fail++;
      $display("FAIL same_rd got old1=%0d prs1_1=%0d prd1=%0d exp 40/40/41", ren_prd_old[11:6], ren_prs1[11:6], ren_prd[11:6]);
    end
    dec_valid = 1; dec_count = 3'd1;
    set_slot(0, 5, 0, 0, 0);
    run_cycle();
    set_idle();
    run_cycle();
    n_cmp++;
    if (ren_prs1[5:0] !== 6'd41) begin
      n_fail++;
      $display("FAIL srat5 got=%0d exp=41", ren_prs1[5:0]);
    end
    run_cycle();
  endtask

  task automatic test_stall();
    int n_acc = 0, n_val = 0;
    set_idle();
    ren_ready = 0;
    for (int c = 0; c < 5; c++) begin
      rand_group();
      run_cycle();
      if (last_ready) n_acc++;
    end
    n_cmp++;
    if (n_acc !== 2 || last_ready !== 1'b0 || ren_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall got acc=%0d ready=%b valid=%b exp 2/0/1", n_acc, last_ready, ren_valid);
    end
    set_idle();
    for (int c = 0; c < 2; c++) begin
      run_cycle();
      if (last_valid) n_val++;
    end
    run_cycle();
    n_cmp++;
    if (n_val !== 2 || last_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain got back_to_back=%0d then valid=%b exp 2/0", n_val, last_valid);
    end
  endtask

  task automatic test_avail();
    set_idle();
    dec_valid = 1; dec_count = 3'd3;
    set_slot(0, 1, 2, 6, 1);
    set_slot(1, 6, 3, 7, 1);
    set_slot(2, 7, 6, 8, 1);
    fl_avail = 6'd2;
    run_cycle();
    n_cmp++;
    if (last_ready !== 1'b0 || last_req !== 3'd0) begin
      n_fail++;
      $display("FAIL avail_low got ready=%b req=%0d exp 0/0", last_ready, last_req);
    end
    fl_avail = 6'd3;
    run_cycle();
    n_cmp++;
    if (last_ready !== 1'b1 || last_req !== 3'd3) begin
      n_fail++;
      $display("FAIL avail_ok got ready=%b req=%0d exp 1/3", last_ready, last_req);
    end
    set_idle();
    repeat (3) run_cycle();
  endtask

  task automatic test_x0();
    set_idle();
    dec_valid = 1; dec_count = 3'd2;
    set_slot(0, 0, 9, 0, 1);
    set_slot(1, 0, 0, 3, 0);
    run_cycle();
    n_cmp++;
    if (last_ready !== 1'b1 || last_req !== 3'd0) begin
      n_fail++;
      $display("FAIL x0_req got ready=%b req=%0d exp 1/0", last_ready, last_req);
    end
    set_idle();
    run_cycle();
    n_cmp++;
    if (ren_rd_we !== 4'b0000 || ren_prd !== 24'd0 || ren_prd_old !== 24'd0 || ren_prs1 !== 24'd0) begin
      n_fail++;
      $display("FAIL x0_group got we=%b prd=%h old=%h prs1=%h exp all 0", ren_rd_we, ren_prd, ren_prd_old, ren_prs1);
    end
    run_cycle();
  endtask

  task automatic test_flush();
    set_idle();
    dec_valid = 1; dec_count = 3'd2;
    set_slot(0, 0, 0, 1, 1);
    set_slot(1, 0, 0, 7, 1);
    run_cycle();
    set_idle();
    dec_valid = 1; dec_count = 3'd1;
    set_slot(0, 0, 0, 2, 1);
    cmt_count = 3'd1; cmt_rd = 20'd1; cmt_prd = 24'd32; cmt_prd_old = 24'd1;
    run_cycle();
    n_cmp++;
    if (last_ret_count !== 3'd1 || last_ret_p[5:0] !== 6'd1) begin
      n_fail++;
      $display("FAIL ret_path got count=%0d p0=%0d exp 1/1", last_ret_count, last_ret_p[5:0]);
    end
    set_idle();
    dec_valid = 1; dec_count = 3'd1;
    set_slot(0, 0, 0, 3, 1);
    flush = 1;
    run_cycle();
    n_cmp++;
    if (last_ready !== 1'b0 || ren_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush got ready=%b next_valid=%b exp 0/0", last_ready, ren_valid);
    end
    set_idle();
    dec_valid = 1; dec_count = 3'd2;
    set_slot(0, 1, 7, 0, 0);
    set_slot(1, 2, 5, 0, 0);
    run_cycle();
    set_idle();
    run_cycle();
    n_cmp++;
    if (ren_prs1 !== {12'd0, 6'd2, 6'd32} || ren_prs2 !== {12'd0, 6'd5, 6'd7}) begin
      n_fail++;
      $display("FAIL flush_map got prs1=%h prs2=%h exp 0000a0/000147", ren_prs1, ren_prs2);
    end
    run_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_idle();
      if ($urandom_range(0, 3) != 0) rand_group();
      fl_avail  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 4)) : 6'd16;
      ren_ready = ($urandom_range(0, 3) != 0);
      cmt_count = 3'($urandom_range(0, 4));
      for (int k = 0; k < 4; k++) begin
        cmt_rd[k*5 +: 5]      = 5'($urandom_range(1, 31));
        cmt_prd[k*6 +: 6]     = 6'($urandom_range(0, 47));
        cmt_prd_old[k*6 +: 6] = 6'($urandom_range(0, 47));
      end
      flush = ($urandom_range(0, 24) == 0);
      run_cycle();
    end
    set_idle();
    repeat (3) run_cycle();
  endtask

  task automatic test_midreset();
    set_idle();
    ren_ready = 0;
    for (int c = 0; c < 3; c++) begin
      rand_group();
      run_cycle();
    end
    rand_group();
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (ren_valid !== 1'b0 || dec_ready !== 1'b0 || fl_req_count !== 3'd0 || ren_prd !== 24'd0) begin
      n_fail++;
      $display("FAIL midreset got valid=%b ready=%b req=%0d prd=%h exp 0/0/0/0", ren_valid, dec_ready, fl_req_count, ren_prd);
    end
    @(negedge clk);
    set_idle();
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    dec_valid = 1; dec_count = 3'd2;
    set_slot(0, 1, 31, 9, 1);
    set_slot(1, 9, 4, 0, 0);
    run_cycle();
    set_idle();
    repeat (3) run_cycle();
    for (int c = 0; c < 30; c++) begin
      set_idle();
      rand_group();
      ren_ready = 1'($urandom);
      run_cycle();
    end
    set_idle();
    repeat (3) run_cycle();
  endtask

  initial begin
    pend_tags = '0;
    test_reset();
    test_basic();
    test_same_rd();
    test_stall();
    test_avail();
    test_x0();
    test_flush();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
